// File: rtl/data_sram_responder_pkg.sv
// Shared constants and helpers for the data SRAM responder: MMIO decode map,
// read-source encoding and the byte-lane merge used by every writable register.
package sram_resp_pkg;

    localparam logic [15:0] MMIO_BASE_HI = 16'hbfaf;

    localparam logic [15:0] OFS_LED   = 16'hf000;
    localparam logic [15:0] OFS_NUM   = 16'hf010;
    localparam logic [15:0] OFS_SW    = 16'hf020;
    localparam logic [15:0] OFS_TIMER = 16'he000;
    localparam logic [15:0] OFS_TCMP  = 16'he004;
    localparam logic [15:0] OFS_TSTAT = 16'he008;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_MMIO = 2'd2
    } rd_src_e;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU data SRAM port bundle: the CPU side is the master, the responder the slave.
interface data_sram_responder_if;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output sram_en,
        output sram_we,
        output sram_addr,
        output sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_en,
        input  sram_we,
        input  sram_addr,
        input  sram_wdata,
        output sram_rdata
    );

endinterface

// File: rtl/data_sram_responder_ram.sv
// Byte-writable word RAM with a registered read port; the read register only
// loads on a read so it holds its value across writes and idle cycles.
module sram_resp_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [0:(1 << AW) - 1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            if (we_i == 4'b0000) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Fixed-latency responder for the CPU data SRAM port: word RAM plus LED/NUM/SWITCH
// MMIO; the timer block exists only when SRAM_RESP_TIMER_EN is defined.
//
//   read source | meaning
//   SRC_NONE    | after reset, sram_rdata reads 0
//   SRC_RAM     | last read hit RAM, return the RAM read register
//   SRC_MMIO    | last read hit MMIO, return the captured register value
module data_sram_responder
    import sram_resp_pkg::*;
#(
    parameter int RAM_AW = 14,
    parameter int LED_W  = 16,
    parameter int SW_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    data_sram_responder_if.slave sram,
    input  logic [SW_W-1:0]      switch_in,
    output logic [LED_W-1:0]     led_out,
    output logic [31:0]          num_out,
    output logic                 timer_irq
);

    logic             is_mmio;
    logic             rd_req;
    logic             wr_req;
    logic             mmio_wr;
    logic [15:0]      ofs;
    logic [31:0]      ram_rdata;
    logic [31:0]      mmio_rd_val;
    logic [31:0]      mmio_rd_q, mmio_rd_d;
    rd_src_e          src_q, src_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      num_q, num_d;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;

    assign is_mmio = (sram.sram_addr[31:16] == MMIO_BASE_HI);
    assign ofs     = sram.sram_addr[15:0];
    assign rd_req  = sram.sram_en && (sram.sram_we == 4'b0000);
    assign wr_req  = sram.sram_en && (sram.sram_we != 4'b0000);
    assign mmio_wr = wr_req && is_mmio;

    // Reset gates RAM access so a request overlapping reset never lands.
    sram_resp_ram #(
        .AW(RAM_AW)
    ) u_ram (
        .clk    (clk),
        .en_i   (sram.sram_en && !is_mmio && !reset),
        .we_i   (sram.sram_we),
        .addr_i (sram.sram_addr[RAM_AW+1:2]),
        .wdata_i(sram.sram_wdata),
        .rdata_o(ram_rdata)
    );

`ifdef SRAM_RESP_TIMER_EN
    logic [31:0] timer_q, timer_d;
    logic [31:0] tcmp_q, tcmp_d;
    logic        pend_q, pend_d;

    always_comb begin
        timer_d = timer_q + 32'd1;
        tcmp_d  = tcmp_q;
        pend_d  = pend_q;
        if (mmio_wr && ofs == OFS_TIMER) begin
            timer_d = lane_merge(timer_q, sram.sram_wdata, sram.sram_we);
        end
        if (mmio_wr && ofs == OFS_TCMP) begin
            tcmp_d = lane_merge(tcmp_q, sram.sram_wdata, sram.sram_we);
        end
        if (mmio_wr && ofs == OFS_TSTAT && sram.sram_we[0] && sram.sram_wdata[0]) begin
            pend_d = 1'b0;
        end
        // A compare hit beats a simultaneous clear.
        if (timer_q == tcmp_q && tcmp_q != 32'd0) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
            tcmp_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            tcmp_q  <= tcmp_d;
            pend_q  <= pend_d;
        end
    end

    assign timer_irq = pend_q;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        mmio_rd_val = '0;
        case (ofs)
            OFS_LED:   mmio_rd_val = 32'(led_q);
            OFS_NUM:   mmio_rd_val = num_q;
            OFS_SW:    mmio_rd_val = 32'(sw_sync_q);
`ifdef SRAM_RESP_TIMER_EN
            OFS_TIMER: mmio_rd_val = timer_q;
            OFS_TCMP:  mmio_rd_val = tcmp_q;
            OFS_TSTAT: mmio_rd_val = {31'b0, pend_q};
`endif
            default:   mmio_rd_val = '0;
        endcase
    end

    always_comb begin
        led_d = led_q;
        num_d = num_q;
        if (mmio_wr && ofs == OFS_LED) begin
            led_d = LED_W'(lane_merge(32'(led_q), sram.sram_wdata, sram.sram_we));
        end
        if (mmio_wr && ofs == OFS_NUM) begin
            num_d = lane_merge(num_q, sram.sram_wdata, sram.sram_we);
        end
    end

    always_comb begin
        src_d     = src_q;
        mmio_rd_d = mmio_rd_q;
        if (rd_req) begin
            if (is_mmio) begin
                src_d     = SRC_MMIO;
                mmio_rd_d = mmio_rd_val;
            end else begin
                src_d = SRC_RAM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q     <= SRC_NONE;
            mmio_rd_q <= '0;
            led_q     <= '0;
            num_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            src_q     <= src_d;
            mmio_rd_q <= mmio_rd_d;
            led_q     <= led_d;
            num_q     <= num_d;
            sw_meta_q <= switch_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign sram.sram_rdata = (src_q == SRC_RAM)  ? ram_rdata :
                             (src_q == SRC_MMIO) ? mmio_rd_q : 32'd0;
    assign led_out = led_q;
    assign num_out = num_q;

endmodule
